// File: rtl/perfect_range_scanner.sv
// Range sequencer for the perfect-number checker: walks N from lo to hi, collects hits in a FWFT FIFO.
// Optional watchdog on the checker handshake is built when SCAN_TIMEOUT_EN is defined.
module perfect_range_scanner #(
    parameter int WIDTH   = 10,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] n_out,
    output logic             go,
    input  logic             chk_done,
    input  logic             chk_perfect,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] count,
    output logic             overflow,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             err
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_STEP  = 3'd3;
    localparam logic [2:0] S_FIN   = 3'd4;
    localparam int AW = $clog2(DEPTH);

    // Reject configurations the pointer arithmetic and watchdog cannot support.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_cfg
        $error("perfect_range_scanner: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
    end

    logic [2:0]       state_q, state_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [WIDTH-1:0] lim_q, lim_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] fifo_mem [DEPTH];
    logic             push_en, pop_en, fifo_empty, fifo_full;

`ifdef SCAN_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wdog_q, wdog_d;
    logic          err_q, err_d;
`endif

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_en     = rd_en && !fifo_empty;

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        lim_d    = lim_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = pop_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
        push_en  = 1'b0;
`ifdef SCAN_TIMEOUT_EN
        wdog_d   = wdog_q;
        err_d    = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    n_d      = lo;
                    lim_d    = hi;
                    count_d  = '0;
                    ovf_d    = 1'b0;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
`ifdef SCAN_TIMEOUT_EN
                    err_d    = 1'b0;
`endif
                    state_d  = (lo > hi) ? S_FIN : S_ISSUE;
                end
            end
            S_ISSUE: begin
`ifdef SCAN_TIMEOUT_EN
                wdog_d  = '0;
`endif
                state_d = (n_q > WIDTH'(1)) ? S_WAIT : S_STEP;
            end
            S_WAIT: begin
                if (chk_done) begin
                    if (chk_perfect) begin
                        if (count_q != '1) begin
                            count_d = count_q + 1'b1;
                        end
                        // A same-cycle pop frees the slot this push needs.
                        if (!fifo_full || pop_en) begin
                            push_en  = 1'b1;
                            wr_ptr_d = wr_ptr_q + 1'b1;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                    state_d = S_STEP;
                end
`ifdef SCAN_TIMEOUT_EN
                else if (wdog_q == TW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_FIN;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
`endif
            end
            S_STEP: begin
                // Compare before increment so hi = all-ones never wraps.
                if (n_q == lim_q) begin
                    state_d = S_FIN;
                end else begin
                    n_d     = n_q + 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= S_IDLE;
            n_q      <= '0;
            lim_q    <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            lim_q    <= lim_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) begin
            fifo_mem[wr_ptr_q[AW-1:0]] <= n_q;
        end
    end

`ifdef SCAN_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (clr) begin
            wdog_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            err_q  <= err_d;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign n_out    = n_q;
    assign go       = (state_q == S_ISSUE) && (n_q > WIDTH'(1));
    assign busy     = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign done     = (state_q == S_FIN);
    assign count    = count_q;
    assign overflow = ovf_q;
    assign empty    = fifo_empty;
    assign rd_data  = fifo_empty ? '0 : fifo_mem[rd_ptr_q[AW-1:0]];

endmodule

// File: tb/tb_perfect_range_scanner.sv
// Directed bench for perfect_range_scanner with a 5-cycle behavioural checker model.
module tb_perfect_range_scanner;
    localparam int WIDTH = 10;

    logic             clk = 1'b0;
    logic             clr, start, chk_done, chk_perfect, rd_en;
    logic [WIDTH-1:0] lo, hi, n_out, count, rd_data;
    logic             go, busy, done, overflow, empty, err;

    int  n_tests = 0;
    int  n_fail  = 0;
    int  go_cnt = 0, go_low = 0, done_cnt = 0;
    int  last_go_n = 0;
    int  rd_q[$];
    bit  mute = 0, force_np = 0;
    int  cd = 0;
    int  pend_n = 0;
    int  go0, done0;

    perfect_range_scanner #(.WIDTH(WIDTH), .DEPTH(2), .TIMEOUT(16)) dut (
        .clk(clk), .clr(clr), .start(start), .lo(lo), .hi(hi),
        .n_out(n_out), .go(go), .chk_done(chk_done), .chk_perfect(chk_perfect),
        .busy(busy), .done(done), .count(count), .overflow(overflow),
        .rd_en(rd_en), .rd_data(rd_data), .empty(empty), .err(err)
    );

    always #5 clk = ~clk;

    function automatic bit is_perfect(input int n);
        return (n == 6) || (n == 28) || (n == 496);
    endfunction

    // Checker model: answers 5 cycles after go; forgets a pending job once the scanner leaves WAIT.
    initial begin
        chk_done = 0;
        chk_perfect = 0;
        forever begin
            @(negedge clk);
            chk_done = 0;
            chk_perfect = 0;
            if (cd > 0) begin
                if (!busy) cd = 0;
                else begin
                    cd--;
                    if (cd == 0) begin
                        chk_done = 1;
                        chk_perfect = !force_np && is_perfect(pend_n);
                    end
                end
            end
            if (go && !mute) begin
                cd = 5;
                pend_n = int'(n_out);
            end
        end
    end

    always @(negedge clk) begin
        if (go) begin
            go_cnt++;
            last_go_n = int'(n_out);
            if (n_out < 2) go_low++;
        end
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic start_scan(input int l, input int h);
        @(negedge clk);
        go0 = go_cnt;
        done0 = done_cnt;
        lo = WIDTH'(l);
        hi = WIDTH'(h);
        start = 1;
        @(negedge clk);
        start = 0;
    endtask

    task automatic run_scan(input bit do_reads, input int budget);
        int cyc = 0;
        bit seen = 0;
        while (!seen && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (done) seen = 1;
            if (do_reads && !empty) begin
                rd_q.push_back(int'(rd_data));
                rd_en = 1;
            end else rd_en = 0;
        end
        @(negedge clk);
        rd_en = 0;
        check("scan_done_seen", 32'(seen), 32'd1);
    endtask

    task automatic pop_expect(input string tag, input int exp);
        check(tag, 32'(rd_data), 32'(exp));
        rd_en = 1;
        @(negedge clk);
        rd_en = 0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_n_out"}, 32'(n_out), 0);
        check({tag, "_go"}, 32'(go), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_count"}, 32'(count), 0);
        check({tag, "_overflow"}, 32'(overflow), 0);
        check({tag, "_err"}, 32'(err), 0);
        check({tag, "_rd_data"}, 32'(rd_data), 0);
        check({tag, "_empty"}, 32'(empty), 1);
    endtask

    initial begin
        clr = 1; start = 0; rd_en = 0; lo = '0; hi = '0;
        repeat (3) @(negedge clk);
        clr = 0;
        check_reset("reset");

        // 1..30: hits 6 and 28; N=1 must not issue go.
        start_scan(1, 30);
        check("t1_busy", 32'(busy), 1);
        check("t1_go_n1", 32'(go), 0);
        run_scan(0, 1000);
        $display("[TB] scan lo=1 hi=30 count=%0d gos=%0d", count, go_cnt - go0);
        check("t1_gos", 32'(go_cnt - go0), 29);
        check("t1_go_low", 32'(go_low), 0);
        check("t1_done_cnt", 32'(done_cnt - done0), 1);
        check("t1_count", 32'(count), 2);
        check("t1_overflow", 32'(overflow), 0);
        pop_expect("t1_rd0", 6);
        pop_expect("t1_rd1", 28);
        check("t1_empty", 32'(empty), 1);

        // Empty range: done in the cycle after start.
        start_scan(5, 3);
        $display("[TB] scan lo=5 hi=3 done=%0d", done);
        check("t2_done_k1", 32'(done), 1);
        check("t2_go", 32'(go), 0);
        repeat (2) @(negedge clk);
        check("t2_done_pulse", 32'(done), 0);
        check("t2_gos", 32'(go_cnt - go0), 0);
        check("t2_count", 32'(count), 0);
        check("t2_empty", 32'(empty), 1);

        // 2..500 without reads into a 2-deep FIFO: 496 is dropped.
        start_scan(2, 500);
        check("t3_go_k1", 32'(go), 1);
        check("t3_n_out_k1", 32'(n_out), 2);
        run_scan(0, 5000);
        $display("[TB] scan lo=2 hi=500 noread count=%0d ovf=%0d", count, overflow);
        check("t3_count", 32'(count), 3);
        check("t3_overflow", 32'(overflow), 1);
        pop_expect("t3_rd0", 6);
        pop_expect("t3_rd1", 28);
        check("t3_empty", 32'(empty), 1);

        // Same range with the host draining every hit.
        rd_q.delete();
        start_scan(2, 500);
        run_scan(1, 5000);
        $display("[TB] scan lo=2 hi=500 read count=%0d reads=%0d", count, rd_q.size());
        check("t4_nreads", 32'(rd_q.size()), 3);
        if (rd_q.size() == 3) begin
            check("t4_rd0", 32'(rd_q[0]), 6);
            check("t4_rd1", 32'(rd_q[1]), 28);
            check("t4_rd2", 32'(rd_q[2]), 496);
        end
        check("t4_overflow", 32'(overflow), 0);
        check("t4_count", 32'(count), 3);

        // Top of range: single N = 1023, no wrap.
        force_np = 1;
        start_scan(1023, 1023);
        run_scan(0, 100);
        force_np = 0;
        repeat (5) @(negedge clk);
        $display("[TB] scan lo=1023 hi=1023 gos=%0d last_n=%0d", go_cnt - go0, last_go_n);
        check("t5_gos", 32'(go_cnt - go0), 1);
        check("t5_go_n", 32'(last_go_n), 1023);
        check("t5_done_cnt", 32'(done_cnt - done0), 1);
        check("t5_count", 32'(count), 0);
        check("t5_busy", 32'(busy), 0);

        // clr in the middle of WAIT at N=17, then a fresh scan.
        begin
            int cyc = 0;
            start_scan(1, 30);
            while (!(go && n_out == 17) && cyc < 500) begin
                @(negedge clk);
                cyc++;
            end
            check("t6_reached_17", 32'(go && n_out == 17), 1);
        end
        repeat (2) @(negedge clk);
        check("t6_in_wait", 32'(busy), 1);
        clr = 1;
        @(negedge clk);
        clr = 0;
        $display("[TB] clr at N=17");
        check_reset("t6_clr");
        start_scan(1, 30);
        run_scan(0, 1000);
        $display("[TB] rescan lo=1 hi=30 count=%0d", count);
        check("t6_count", 32'(count), 2);
        pop_expect("t6_rd0", 6);
        pop_expect("t6_rd1", 28);

        // Checker never answers.
        mute = 1;
        start_scan(3, 3);
        check("t7_go", 32'(go), 1);
`ifdef SCAN_TIMEOUT_EN
        begin
            int n = 0;
            while (!done && n < 100) begin
                @(negedge clk);
                n++;
            end
            $display("[TB] timeout done after %0d cycles err=%0d", n, err);
            check("t7_done_delay", 32'(n), 17);
            check("t7_err", 32'(err), 1);
        end
`else
        repeat (200) @(negedge clk);
        $display("[TB] silent checker busy=%0d", busy);
        check("t7_busy_held", 32'(busy), 1);
        check("t7_no_done", 32'(done_cnt - done0), 0);
`endif
        clr = 1;
        @(negedge clk);
        clr = 0;
        mute = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
